// File: rtl/freds_marquee.sv
// Item-code marquee: latches a 3-bit UPC on load and drives NUM_DIGITS seven-segment digits with the item name.
// Names longer than NUM_DIGITS scroll left circularly. Optional macro STOLEN_BLINK_EN blinks stolen items.
package freds_marquee_pkg;
  localparam logic [6:0] G_A = 7'b1110111, G_B = 7'b1111100, G_C = 7'b0111001, G_D = 7'b1011110;
  localparam logic [6:0] G_E = 7'b1111001, G_F = 7'b1110001, G_G = 7'b1101111, G_H = 7'b1110100;
  localparam logic [6:0] G_I = 7'b0010000, G_L = 7'b0111000, G_P = 7'b1110011, G_R = 7'b1010000;
  localparam logic [6:0] G_S = 7'b1101101, G_BLANK = 7'b0000000, G_DASH = 7'b1000000;

  // Zero length marks an undefined code.
  function automatic logic [2:0] word_len(input logic [2:0] code);
    case (code)
      3'd0:    word_len = 3'd3;
      3'd1:    word_len = 3'd5;
      3'd3:    word_len = 3'd4;
      3'd4:    word_len = 3'd6;
      3'd5:    word_len = 3'd3;
      3'd6:    word_len = 3'd4;
      default: word_len = 3'd0;
    endcase
  endfunction

  function automatic logic code_valid(input logic [2:0] code);
    code_valid = (word_len(code) != 3'd0);
  endfunction

  // Indices past the end of the word (including the scroll gap) read as blank.
  function automatic logic [6:0] word_char(input logic [2:0] code, input logic [2:0] idx);
    word_char = G_BLANK;
    case (code)
      3'd0: case (idx) 3'd0: word_char = G_B; 3'd1: word_char = G_E; 3'd2: word_char = G_D;
              default: word_char = G_BLANK; endcase
      3'd1: case (idx) 3'd0: word_char = G_A; 3'd1: word_char = G_P; 3'd2: word_char = G_P;
              3'd3: word_char = G_L; 3'd4: word_char = G_E; default: word_char = G_BLANK; endcase
      3'd3: case (idx) 3'd0: word_char = G_B; 3'd1: word_char = G_E; 3'd2: word_char = G_E;
              3'd3: word_char = G_F; default: word_char = G_BLANK; endcase
      3'd4: case (idx) 3'd0: word_char = G_F; 3'd1: word_char = G_R; 3'd2: word_char = G_I;
              3'd3: word_char = G_D; 3'd4: word_char = G_G; 3'd5: word_char = G_E;
              default: word_char = G_BLANK; endcase
      3'd5: case (idx) 3'd0: word_char = G_C; 3'd1: word_char = G_A; 3'd2: word_char = G_R;
              default: word_char = G_BLANK; endcase
      3'd6: case (idx) 3'd0: word_char = G_F; 3'd1: word_char = G_I; 3'd2: word_char = G_S;
              3'd3: word_char = G_H; default: word_char = G_BLANK; endcase
      default: word_char = G_BLANK;
    endcase
  endfunction
endpackage

module freds_marquee_digit
  import freds_marquee_pkg::*;
#(
  parameter int K = 0
) (
  input  logic [2:0] code_i,
  input  logic [2:0] offset_i,
  input  logic       scroll_i,
  output logic [6:0] glyph_o
);
  logic [3:0] per_w;
  logic [3:0] idx_w;

  // offset < P and K < P whenever scrolling, so one subtraction is a full mod P.
  always_comb begin
    per_w = {1'b0, word_len(code_i)} + 4'd1;
    idx_w = {1'b0, offset_i} + 4'(K);
    if (scroll_i && idx_w >= per_w) idx_w = idx_w - per_w;
    glyph_o = code_valid(code_i) ? word_char(code_i, idx_w[2:0]) : G_DASH;
  end
endmodule

module freds_marquee
  import freds_marquee_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCROLL_DIV = 25000000,
  parameter int BLINK_DIV  = 12500000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [2:0]              upc,
  input  logic                    stolen,
  output logic [7*NUM_DIGITS-1:0] hex,
  output logic                    valid,
  output logic                    scrolling,
  output logic                    wrap
);
  localparam int DIV_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

  logic [2:0]       code_q, code_d;
  logic             loaded_q, loaded_d;
  logic [2:0]       offset_q, offset_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             wrap_d, valid_d, scroll_d, blank_d;
  logic             scroll_now;
  logic [7*NUM_DIGITS-1:0] hex_q, hex_d;
  logic             valid_q, scrolling_q, wrap_q;
  logic [NUM_DIGITS-1:0][6:0] glyph_w;

  always_comb begin
    code_d     = code_q;
    loaded_d   = loaded_q;
    offset_d   = offset_q;
    div_d      = div_q;
    wrap_d     = 1'b0;
    scroll_now = loaded_q && code_valid(code_q) && (int'(word_len(code_q)) > NUM_DIGITS);
    if (load) begin
      code_d   = upc;
      loaded_d = 1'b1;
      offset_d = 3'd0;
      div_d    = '0;
    end else if (scroll_now) begin
      if (div_q == DIV_W'(SCROLL_DIV - 1)) begin
        div_d = '0;
        // Sequence period is L+1, so the last offset equals L.
        if (offset_q == word_len(code_q)) begin
          offset_d = 3'd0;
          wrap_d   = 1'b1;
        end else begin
          offset_d = offset_q + 3'd1;
        end
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
    valid_d  = loaded_d && code_valid(code_d);
    scroll_d = valid_d && (int'(word_len(code_d)) > NUM_DIGITS);
  end

  // Digit g is the g-th from the left, which lives in the MSB end of hex.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    freds_marquee_digit #(.K(g)) u_dig (
      .code_i  (code_d),
      .offset_i(offset_d),
      .scroll_i(scroll_d),
      .glyph_o (glyph_w[NUM_DIGITS-1-g])
    );
  end

`ifdef STOLEN_BLINK_EN
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
  logic             blk_off_q, blk_off_d;
  logic             stolen_q, stolen_d;

  always_comb begin
    stolen_d  = load ? stolen : stolen_q;
    blk_cnt_d = blk_cnt_q;
    blk_off_d = blk_off_q;
    if (load) begin
      blk_cnt_d = '0;
      blk_off_d = 1'b0;
    end else if (blk_cnt_q == BLK_W'(BLINK_DIV - 1)) begin
      blk_cnt_d = '0;
      blk_off_d = ~blk_off_q;
    end else begin
      blk_cnt_d = blk_cnt_q + BLK_W'(1);
    end
    blank_d = blk_off_d && stolen_d && valid_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blk_cnt_q <= '0;
      blk_off_q <= 1'b0;
      stolen_q  <= 1'b0;
    end else begin
      blk_cnt_q <= blk_cnt_d;
      blk_off_q <= blk_off_d;
      stolen_q  <= stolen_d;
    end
  end
`else
  logic unused_blink;
  assign unused_blink = ^{stolen, 32'(BLINK_DIV)};
  assign blank_d = 1'b0;
`endif

  assign hex_d = (loaded_d && !blank_d) ? glyph_w : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      code_q      <= 3'd0;
      loaded_q    <= 1'b0;
      offset_q    <= 3'd0;
      div_q       <= '0;
      hex_q       <= '0;
      valid_q     <= 1'b0;
      scrolling_q <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      code_q      <= code_d;
      loaded_q    <= loaded_d;
      offset_q    <= offset_d;
      div_q       <= div_d;
      hex_q       <= hex_d;
      valid_q     <= valid_d;
      scrolling_q <= scroll_d;
      wrap_q      <= wrap_d;
    end
  end

  assign hex       = hex_q;
  assign valid     = valid_q;
  assign scrolling = scrolling_q;
  assign wrap      = wrap_q;
endmodule
